// File: rtl/key_stepped_serializer_if.sv
// Signal bundle between the key-stepped serializer and its environment:
// raw key and load/pattern in, serial bit plus step/busy/done/bit_idx out.
interface key_stepped_serializer_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH + 1);

  logic             key_n;
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic             w;
  logic             step;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;

  modport master (
    output key_n, load, pattern,
    input  w, step, busy, done, bit_idx
  );

  modport slave (
    input  key_n, load, pattern,
    output w, step, busy, done, bit_idx
  );
endinterface

// File: rtl/key_stepped_serializer.sv
// Debounces an active-low key into one-cycle step pulses and shifts a loaded
// pattern out MSB first, one bit per clean press.
module key_stepped_serializer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic                     clock,
  input logic                     resetn,
  key_stepped_serializer_if.slave sif
);
  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       key_sync;
  logic             key_stable, key_stable_d, press_q;
  logic [CNT_W-1:0] db_cnt;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             step_c;

  // Synchronizer, debouncer and falling-edge detect on the stable level.
  // press_q is the extra stage that aligns the step with the key latency.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_sync     <= 2'b11;
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      db_cnt       <= '0;
      press_q      <= 1'b0;
    end else begin
      key_sync     <= {key_sync[0], sif.key_n};
      key_stable_d <= key_stable;
      press_q      <= key_stable_d & ~key_stable;
      if (key_sync[1] == key_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        key_stable <= key_sync[1];
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    step_c  = 1'b0;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (press_q && !sif.load) begin
          step_c = 1'b1;
          sr_d   = {sr_q[WIDTH-2:0], 1'b0};
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WIDTH - 1)) state_d = DONE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    // Load wins over everything, including a coincident press.
    if (sif.load) begin
      state_d = SHIFT;
      sr_d    = sif.pattern;
      idx_d   = '0;
    end
  end

  assign sif.w       = (state_q == SHIFT) & sr_q[WIDTH-1];
  assign sif.step    = step_c;
  assign sif.busy    = (state_q == SHIFT);
  assign sif.done    = (state_q == DONE);
  assign sif.bit_idx = idx_q;
endmodule

// File: tb/tb_key_stepped_serializer.sv
// Randomized and directed bench for key_stepped_serializer against a
// run-length key model and an index-based pattern model.
module tb_key_stepped_serializer;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int IW = $clog2(W + 1);

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  key_stepped_serializer_if #(.WIDTH(W)) sif ();

  key_stepped_serializer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock  (clock),
    .resetn (resetn),
    .sif    (sif)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Model: debounced level changes after D+1 consecutive samples that differ
  // from it; a falling change yields a step visible 3 edges later.
  int         ecount;
  logic       m_stable;
  int         m_run;
  int         press_due[$];
  int         m_mode, m_mode_n;
  logic [W-1:0] m_pat, m_pat_n;
  int         m_cnt, m_cnt_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stable = 1'b1;
    m_run    = 0;
    press_due.delete();
    m_mode = 0; m_mode_n = 0;
    m_pat  = '0; m_pat_n = '0;
    m_cnt  = 0; m_cnt_n = 0;
  endtask

  task automatic model_edge();
    ecount++;
    m_mode = m_mode_n;
    m_pat  = m_pat_n;
    m_cnt  = m_cnt_n;
    if (sif.key_n !== m_stable) begin
      m_run++;
      if (m_run == D + 1) begin
        m_stable = sif.key_n;
        m_run    = 0;
        if (!m_stable) press_due.push_back(ecount + 3);
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_cycle();
    bit press_now;
    bit st;
    press_now = 1'b0;
    if (press_due.size() > 0 && press_due[0] == ecount) begin
      press_now = 1'b1;
      void'(press_due.pop_front());
    end
    st = press_now && (m_mode == 1) && !sif.load;
    chk("step",    32'(sif.step),    32'(st));
    chk("busy",    32'(sif.busy),    32'(m_mode == 1));
    chk("done",    32'(sif.done),    32'(m_mode == 2));
    chk("w",       32'(sif.w),       (m_mode == 1) ? 32'(m_pat[W-1-m_cnt]) : 32'd0);
    chk("bit_idx", 32'(sif.bit_idx), 32'(m_cnt));
    m_mode_n = m_mode;
    m_pat_n  = m_pat;
    m_cnt_n  = m_cnt;
    if (sif.load) begin
      m_mode_n = 1;
      m_pat_n  = sif.pattern;
      m_cnt_n  = 0;
    end else if (st) begin
      m_cnt_n = m_cnt + 1;
      if (m_cnt_n == W) m_mode_n = 2;
    end
  endtask

  task automatic cyc(input logic k, input logic ld, input logic [W-1:0] p);
    @(posedge clock);
    model_edge();
    #1;
    sif.key_n   = k;
    sif.load    = ld;
    sif.pattern = p;
    @(negedge clock);
    check_cycle();
  endtask

  task automatic press(input int lo, input int hi);
    repeat (lo) cyc(1'b0, 1'b0, '0);
    repeat (hi) cyc(1'b1, 1'b0, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_w"},    32'(sif.w),       32'd0);
    chk({tag, "_step"}, 32'(sif.step),    32'd0);
    chk({tag, "_busy"}, 32'(sif.busy),    32'd0);
    chk({tag, "_done"}, 32'(sif.done),    32'd0);
    chk({tag, "_idx"},  32'(sif.bit_idx), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] p;
    logic         lvl;
    int           len;
    sif.key_n   = 1'b1;
    sif.load    = 1'b0;
    sif.pattern = '0;
    ecount = 0;
    model_reset();

    #2 chk_reset_outputs("rst");
    #10 resetn = 1'b1;

    // Idle after reset
    repeat (20) cyc(1'b1, 1'b0, '0);

    // Full run, then a 9th press in DONE
    cyc(1'b1, 1'b1, 8'b1101_0110);
    repeat (8) press(8, 8);
    press(8, 8);

    // Press bounce then release bounce
    cyc(1'b1, 1'b1, 8'h3C);
    repeat (5) begin
      repeat (2) cyc(1'b0, 1'b0, '0);
      repeat (2) cyc(1'b1, 1'b0, '0);
    end
    repeat (20) cyc(1'b0, 1'b0, '0);
    repeat (5) begin
      repeat (2) cyc(1'b1, 1'b0, '0);
      repeat (2) cyc(1'b0, 1'b0, '0);
    end
    repeat (20) cyc(1'b1, 1'b0, '0);

    // Long hold gives one step; a fresh press gives another
    press(100, 20);
    press(10, 10);

    // Load lands in the same cycle as a press event
    cyc(1'b1, 1'b1, 8'h0F);
    repeat (8) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 8'hA5);
    repeat (5) cyc(1'b0, 1'b0, '0);
    repeat (10) cyc(1'b1, 1'b0, '0);

    // Randomized key levels, run lengths and occasional loads
    cyc(1'b1, 1'b1, W'($urandom));
    repeat (150) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      repeat (len) begin
        p = W'($urandom);
        cyc(lvl, ($urandom_range(0, 39) == 0), p);
      end
    end

    // Async reset mid-run with the key held through it
    cyc(1'b1, 1'b1, 8'h96);
    repeat (3) press(8, 8);
    repeat (4) cyc(1'b0, 1'b0, '0);
    #1 resetn = 1'b0;
    #1 chk_reset_outputs("arst");
    model_reset();
    #1 resetn = 1'b1;
    repeat (30) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 8'hF0);
    repeat (20) cyc(1'b0, 1'b0, '0);
    repeat (10) cyc(1'b1, 1'b0, '0);
    press(10, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
